// File: rtl/rv32c_pkg.sv
// Types and helpers for the RV32C halfword fetch path.
package rv32c_pkg;
   typedef logic [15:0] halfword_t;
   typedef enum logic {RUN, DISCARD} aligner_state_t;

   localparam int HW_DEPTH = 4;
   localparam int CNT_W    = 3;

   function automatic logic is_compressed(input halfword_t hw);
      return hw[1:0] != 2'b11;
   endfunction
endpackage

// File: rtl/rv32i_types_pkg.sv
// Base RV32I scalar types that the fetch and decode blocks share.
package rv32i_types_pkg;
   typedef logic [31:0] word_t;
endpackage

// File: rtl/rv32c_hw_queue.sv
// 4-entry halfword shift queue: pop 0/1/2 from the head, then push 0/1/2 at the new tail, same cycle.
// One-cycle write latency; the caller guarantees no overflow and flush overrides everything.
module rv32c_hw_queue
   import rv32c_pkg::*;
(
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush_i,
   input  logic             pop1_i,
   input  logic             pop2_i,
   input  logic             push1_i,
   input  logic             push2_i,
   input  halfword_t        push_lo_i,
   input  halfword_t        push_hi_i,
   output halfword_t        hw0_o,
   output halfword_t        hw1_o,
   output logic [CNT_W-1:0] count_o
);

   halfword_t        hw_q [HW_DEPTH];
   halfword_t        hw_d [HW_DEPTH];
   logic [CNT_W-1:0] count_q, count_d, cnt_pop;

   always_comb begin
      for (int i = 0; i < HW_DEPTH; i++) hw_d[i] = hw_q[i];
      cnt_pop = count_q;
      if (pop2_i) begin
         for (int i = 0; i < HW_DEPTH - 2; i++) hw_d[i] = hw_q[i + 2];
         cnt_pop = count_q - CNT_W'(2);
      end else if (pop1_i) begin
         for (int i = 0; i < HW_DEPTH - 1; i++) hw_d[i] = hw_q[i + 1];
         cnt_pop = count_q - CNT_W'(1);
      end
      count_d = cnt_pop;
      // Pushes land relative to the post-pop count so pop and push can share a cycle.
      if (push2_i) begin
         for (int i = 0; i < HW_DEPTH; i++) begin
            if (CNT_W'(i) == cnt_pop)              hw_d[i] = push_lo_i;
            if (CNT_W'(i) == cnt_pop + CNT_W'(1))  hw_d[i] = push_hi_i;
         end
         count_d = cnt_pop + CNT_W'(2);
      end else if (push1_i) begin
         for (int i = 0; i < HW_DEPTH; i++) begin
            if (CNT_W'(i) == cnt_pop) hw_d[i] = push_hi_i;
         end
         count_d = cnt_pop + CNT_W'(1);
      end
      if (flush_i) count_d = '0;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count_q <= '0;
         for (int i = 0; i < HW_DEPTH; i++) hw_q[i] <= '0;
      end else begin
         count_q <= count_d;
         for (int i = 0; i < HW_DEPTH; i++) hw_q[i] <= hw_d[i];
      end
   end

   assign hw0_o   = hw_q[0];
   assign hw1_o   = hw_q[1];
   assign count_o = count_q;

endmodule

// File: rtl/rv32c_fetch_aligner.sv
// Realigns word fetches into 16/32-bit RV32C instructions, one per handshake; output is registered-state decode.
// Fetch requests stop when the queue holds 3+ halfwords; redirects flush and drop any outstanding read.
module rv32c_fetch_aligner
   import rv32c_pkg::*;
   import rv32i_types_pkg::*;
#(
   parameter word_t RESET_PC = 32'h0000_0200
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fetch_ren,
   output logic [31:0] fetch_addr,
   input  logic        fetch_ready,
   input  logic [31:0] fetch_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_raw,
   output logic        inst_compressed,
   output logic [31:0] inst_pc
);

   localparam word_t RESET_WORD = {RESET_PC[31:2], 2'b00};

   aligner_state_t   state_q, state_d;
   logic             skip_low_q, skip_low_d;
   word_t            pc_q, pc_d;
   word_t            fetch_addr_q, fetch_addr_d;
   word_t            target_q, target_d;

   halfword_t        hw0, hw1;
   logic [CNT_W-1:0] count;
   logic             hw0_c, consume, append;
   word_t            redir_word;

   rv32c_hw_queue u_queue (
      .CLK       (CLK),
      .nRST      (nRST),
      .flush_i   (redirect),
      .pop1_i    (consume & hw0_c),
      .pop2_i    (consume & ~hw0_c),
      .push1_i   (append & skip_low_q),
      .push2_i   (append & ~skip_low_q),
      .push_lo_i (fetch_rdata[15:0]),
      .push_hi_i (fetch_rdata[31:16]),
      .hw0_o     (hw0),
      .hw1_o     (hw1),
      .count_o   (count)
   );

   assign hw0_c      = is_compressed(hw0);
   assign redir_word = {redirect_pc[31:2], 2'b00};

   // Registered count only, so inst_ready never reaches the memory request.
   assign fetch_ren  = (state_q == DISCARD) || (count <= CNT_W'(2));
   assign inst_valid = (state_q == RUN) && (count != '0) && (hw0_c || count >= CNT_W'(2));
   assign inst_raw   = hw0_c ? {16'h0000, hw0} : {hw1, hw0};
   assign inst_compressed = hw0_c;
   assign inst_pc    = pc_q;
   assign fetch_addr = fetch_addr_q;

   assign consume = inst_valid && inst_ready && !redirect;
   assign append  = (state_q == RUN) && fetch_ren && fetch_ready && !redirect;

   always_comb begin
      state_d      = state_q;
      skip_low_d   = skip_low_q;
      pc_d         = pc_q;
      fetch_addr_d = fetch_addr_q;
      target_d     = target_q;
      if (redirect) begin
         pc_d       = redirect_pc & ~word_t'(1);
         skip_low_d = redirect_pc[1];
         // An issued read cannot be cancelled: wait it out at the old address, then jump.
         if (fetch_ren && !fetch_ready) begin
            state_d  = DISCARD;
            target_d = redir_word;
         end else begin
            state_d      = RUN;
            fetch_addr_d = redir_word;
         end
      end else if (state_q == DISCARD) begin
         if (fetch_ready) begin
            state_d      = RUN;
            fetch_addr_d = target_q;
         end
      end else begin
         if (consume) pc_d = pc_q + (hw0_c ? 32'd2 : 32'd4);
         if (append) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
            skip_low_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= RUN;
         skip_low_q   <= RESET_PC[1];
         pc_q         <= RESET_PC & ~word_t'(1);
         fetch_addr_q <= RESET_WORD;
         target_q     <= RESET_WORD;
      end else begin
         state_q      <= state_d;
         skip_low_q   <= skip_low_d;
         pc_q         <= pc_d;
         fetch_addr_q <= fetch_addr_d;
         target_q     <= target_d;
      end
   end

endmodule

// File: tb/tb_rv32c_fetch_aligner.sv
// Directed bench for rv32c_fetch_aligner with a zero/variable-wait memory model and an issue log.
module tb_rv32c_fetch_aligner;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fetch_ren;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic [31:0] fetch_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_raw;
   logic        inst_compressed;
   logic [31:0] inst_pc;

   logic        mem_hold;
   logic [31:0] mem [logic [31:0]];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] raw;
      logic        c;
   } ent_t;
   ent_t log_q[$];

   int checks = 0;
   int errors = 0;

   rv32c_fetch_aligner #(.RESET_PC(32'h0000_0200)) dut (
      .CLK             (CLK),
      .nRST            (nRST),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .fetch_ren       (fetch_ren),
      .fetch_addr      (fetch_addr),
      .fetch_ready     (fetch_ready),
      .fetch_rdata     (fetch_rdata),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst_raw        (inst_raw),
      .inst_compressed (inst_compressed),
      .inst_pc         (inst_pc)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0001_0001;
   endfunction

   function automatic ent_t ent(input int i);
      ent_t e;
      e.pc  = 32'hFFFF_FFFF;
      e.raw = 32'hFFFF_FFFF;
      e.c   = 1'bx;
      if (i < log_q.size()) e = log_q[i];
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: drive memory response, log any handshake, advance one cycle.
   task automatic cyc();
      #1;
      fetch_rdata = rd(fetch_addr);
      fetch_ready = fetch_ren & ~mem_hold;
      #1;
      if (inst_valid && inst_ready && !redirect)
         log_q.push_back('{inst_pc, inst_raw, inst_compressed});
      @(negedge CLK);
   endtask

   task automatic reset_dut();
      nRST        = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      inst_ready  = 1'b1;
      mem_hold    = 1'b0;
      fetch_ready = 1'b0;
      fetch_rdata = 32'h0;
      @(negedge CLK);
      nRST = 1'b1;
      log_q.delete();
   endtask

   task automatic chk_ent(input string tag, input int i, input logic [31:0] pc,
                          input logic [31:0] raw, input logic c);
      ent_t e;
      e = ent(i);
      chk({tag, "_pc"}, e.pc, pc);
      chk({tag, "_raw"}, e.raw, raw);
      chk({tag, "_c"}, 32'(e.c), 32'(c));
   endtask

   initial begin
      int bad;

      // Reset values and two compressed instructions from one word
      mem.delete();
      mem[32'h200] = 32'h4505_4501;
      nRST = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
      mem_hold = 1'b0; fetch_ready = 1'b0; fetch_rdata = 32'h0;
      @(negedge CLK);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_raw", inst_raw, 32'h0);
      chk("rst_c", 32'(inst_compressed), 32'd1);
      chk("rst_pc", inst_pc, 32'h200);
      chk("rst_faddr", fetch_addr, 32'h200);
      chk("rst_ren", 32'(fetch_ren), 32'd1);
      nRST = 1'b1;
      log_q.delete();
      cyc();
      chk("t1_faddr", fetch_addr, 32'h204);
      chk("t1_valid", 32'(inst_valid), 32'd1);
      repeat (3) cyc();
      chk_ent("t1_i0", 0, 32'h200, 32'h0000_4501, 1'b1);
      chk_ent("t1_i1", 1, 32'h202, 32'h0000_4505, 1'b1);

      // Straddling 32-bit instruction, zero-wait
      mem.delete();
      mem[32'h200] = 32'h0513_4501;
      mem[32'h204] = 32'h4505_0000;
      reset_dut();
      repeat (6) cyc();
      chk_ent("t2_i0", 0, 32'h200, 32'h0000_4501, 1'b1);
      chk_ent("t2_i1", 1, 32'h202, 32'h0000_0513, 1'b0);
      chk_ent("t2_i2", 2, 32'h206, 32'h0000_4505, 1'b1);

      // Straddle with the second word delayed three cycles
      reset_dut();
      cyc();
      mem_hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("t2b_valid", 32'(inst_valid), 32'd0);
         chk("t2b_ren", 32'(fetch_ren), 32'd1);
         chk("t2b_faddr", fetch_addr, 32'h204);
      end
      mem_hold = 1'b0;
      repeat (5) cyc();
      chk_ent("t2b_i1", 1, 32'h202, 32'h0000_0513, 1'b0);
      chk_ent("t2b_i2", 2, 32'h206, 32'h0000_4505, 1'b1);

      // Redirect to a halfword target with memory idle
      mem.delete();
      mem[32'h300] = 32'h4505_AAAA;
      reset_dut();
      repeat (4) cyc();
      redirect = 1'b1;
      redirect_pc = 32'h302;
      cyc();
      redirect = 1'b0;
      log_q.delete();
      chk("t3_faddr", fetch_addr, 32'h300);
      chk("t3_valid0", 32'(inst_valid), 32'd0);
      cyc();
      chk("t3_valid1", 32'(inst_valid), 32'd1);
      chk("t3_pc", inst_pc, 32'h302);
      chk("t3_raw", inst_raw, 32'h0000_4505);
      repeat (4) cyc();
      chk_ent("t3_i0", 0, 32'h302, 32'h0000_4505, 1'b1);
      chk_ent("t3_i1", 1, 32'h304, 32'h0000_0001, 1'b1);
      bad = 0;
      foreach (log_q[i]) if (log_q[i].raw == 32'h0000_AAAA) bad++;
      chk("t3_no_aaaa", 32'(bad), 32'd0);

      // Redirect while a read to 0x208 is outstanding
      mem.delete();
      mem[32'h400] = 32'h4505_4501;
      reset_dut();
      repeat (2) cyc();
      mem_hold = 1'b1;
      cyc();
      chk("t4_ren", 32'(fetch_ren), 32'd1);
      chk("t4_faddr0", fetch_addr, 32'h208);
      redirect = 1'b1;
      redirect_pc = 32'h400;
      cyc();
      redirect = 1'b0;
      log_q.delete();
      for (int k = 0; k < 3; k++) begin
         chk("t4_hold_faddr", fetch_addr, 32'h208);
         chk("t4_hold_ren", 32'(fetch_ren), 32'd1);
         chk("t4_hold_valid", 32'(inst_valid), 32'd0);
         if (k < 2) cyc();
      end
      mem_hold = 1'b0;
      cyc();
      chk("t4_faddr1", fetch_addr, 32'h400);
      chk("t4_valid", 32'(inst_valid), 32'd0);
      repeat (4) cyc();
      chk_ent("t4_i0", 0, 32'h400, 32'h0000_4501, 1'b1);
      chk_ent("t4_i1", 1, 32'h402, 32'h0000_4505, 1'b1);
      bad = 0;
      foreach (log_q[i]) if (log_q[i].pc == 32'h208) bad++;
      chk("t4_no_208", 32'(bad), 32'd0);

      // Backpressure: queue fills, then drains in order
      mem.delete();
      mem[32'h200] = 32'h0009_0005;
      mem[32'h204] = 32'h0011_000D;
      mem[32'h208] = 32'h0019_0015;
      mem[32'h20C] = 32'h0021_001D;
      reset_dut();
      inst_ready = 1'b0;
      repeat (10) cyc();
      chk("t5_ren", 32'(fetch_ren), 32'd0);
      chk("t5_valid", 32'(inst_valid), 32'd1);
      chk("t5_pc", inst_pc, 32'h200);
      chk("t5_raw", inst_raw, 32'h0000_0005);
      chk("t5_faddr", fetch_addr, 32'h208);
      inst_ready = 1'b1;
      repeat (12) cyc();
      for (int i = 0; i < 8; i++)
         chk_ent("t5_drain", i, 32'h200 + 32'(2 * i), 32'(5 + 4 * i), 1'b1);

      // Asynchronous reset while half of a straddling instruction is held
      mem.delete();
      mem[32'h200] = 32'h0513_4501;
      mem[32'h204] = 32'h4505_0000;
      reset_dut();
      cyc();
      mem_hold = 1'b1;
      cyc();
      chk("t6_half_valid", 32'(inst_valid), 32'd0);
      #2;
      nRST = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(inst_valid), 32'd0);
      chk("t6_rst_raw", inst_raw, 32'h0);
      chk("t6_rst_c", 32'(inst_compressed), 32'd1);
      chk("t6_rst_pc", inst_pc, 32'h200);
      chk("t6_rst_faddr", fetch_addr, 32'h200);
      chk("t6_rst_ren", 32'(fetch_ren), 32'd1);
      @(negedge CLK);
      mem_hold = 1'b0;
      nRST = 1'b1;
      log_q.delete();
      cyc();
      chk("t6_faddr", fetch_addr, 32'h204);
      repeat (3) cyc();
      chk_ent("t6_i0", 0, 32'h200, 32'h0000_4501, 1'b1);
      chk_ent("t6_i1", 1, 32'h202, 32'h0000_0513, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv32c_fetch_aligner.md
Name: rv32c_fetch_aligner

Overview:
- Halfword realignment buffer between the instruction memory port and the RV32C decompress/decode path.
- Fetches word-aligned 32-bit words and queues them as halfwords.
- Emits one instruction per handshake: 16-bit compressed (zero-extended) or 32-bit, including 32-bit instructions that straddle a word boundary.
- Handles redirects to halfword-aligned targets and drops any stale in-flight fetch.

Parameters:
RESET_PC, 32'h0000_0200, first instruction address after reset; bit 0 ignored.

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
redirect  input  1  flush and restart at redirect_pc (branch, jump or trap)
redirect_pc  input  32  new PC; bit 0 ignored
fetch_ren  output  1  instruction read request
fetch_addr  output  32  word-aligned read address; bits [1:0] always 0
fetch_ready  input  1  read completes this cycle; fetch_rdata valid
fetch_rdata  input  32  fetched word, little-endian halfwords
inst_valid  output  1  inst_raw/inst_pc valid
inst_ready  input  1  consumer accepts the instruction
inst_raw  output  32  compressed: {16'h0, hw}; otherwise the full 32-bit instruction
inst_compressed  output  1  inst_raw[1:0] != 2'b11
inst_pc  output  32  PC of the presented instruction

Behaviour:
- Storage: 4-halfword queue hw[0..3], count 0..4, hw[0] oldest. State RUN/DISCARD. Regs: skip_low, inst_pc, fetch_addr, target_addr.
- Reset values (async): count=0, state=RUN, inst_pc=RESET_PC, fetch_addr={RESET_PC[31:2],2'b00}, skip_low=RESET_PC[1], inst_valid=0, inst_raw=0, inst_compressed=1.
- fetch_ren = (state==DISCARD) | (count<=2). Uses registered count only, so there is no combinational path from inst_ready. fetch_ren=1 out of reset.
- fetch_addr and fetch_ren are held stable while fetch_ren=1 and fetch_ready=0.
- Output decode (combinational from registers):
  - inst_valid = count>=1 & (hw[0][1:0]!=2'b11 | count>=2).
  - Compressed: inst_raw={16'h0,hw[0]}. Else inst_raw={hw[1],hw[0]}.
  - inst_valid=0 in DISCARD (queue is empty there anyway).
- Consume (inst_valid & inst_ready & !redirect): pop 1 halfword (compressed) or 2; inst_pc += 2 or 4.
- Append (state==RUN & fetch_ren & fetch_ready & !redirect):
  - skip_low=1: push rdata[31:16] only (+1), then clear skip_low.
  - Else push rdata[15:0] then rdata[31:16] (+2).
  - fetch_addr += 4, wrapping mod 2^32.
- Same-cycle consume and append: pop first, then push at the resulting count. count never exceeds 4.
- Redirect has highest priority and overrides consume and append in the same cycle:
  - Next cycle: count=0, inst_pc=redirect_pc & ~1, skip_low=redirect_pc[1]. A consume handshake in the redirect cycle is ignored.
  - If fetch_ren & !fetch_ready in the redirect cycle (request outstanding): state→DISCARD, fetch_addr held, target_addr={redirect_pc[31:2],2'b00}.
  - Otherwise fetch_addr={redirect_pc[31:2],2'b00} next cycle. fetch_ready data in the redirect cycle is dropped.
- DISCARD:
  - fetch_ren=1 at the old address.
  - On fetch_ready: data dropped, fetch_addr←target_addr, state→RUN.
  - A further redirect in DISCARD updates target_addr, skip_low and inst_pc; stays in DISCARD.
- Latency: redirect in cycle N with memory idle → new fetch_addr in N+1; zero-wait data in N+1 → inst_valid in N+2.
- Throughput: one instruction per cycle in steady state with zero-wait memory.
- Boundaries:
  - count==4 or 3 → fetch_ren=0. count==1 holding the low half of a 32-bit instruction → inst_valid=0 until the next word arrives.
  - Async reset mid-operation discards all state, including a half-held straddling instruction.

Decomposition:
- rv32c_pkg: halfword_t (logic[15:0]), aligner_state_t enum {RUN, DISCARD}, HW_DEPTH=4, is_compressed() function (bits[1:0]!=2'b11).
- word_t is imported from rv32i_types_pkg.
- One sub-module, rv32c_hw_queue: 4-entry halfword shift queue with push1/push2/pop1/pop2/flush and count. The FSM and PC logic stay in the top.

Test Plan:
- RESET_PC=0x200, word@0x200=0x4505_4501, inst_ready=1 → (pc 0x200, raw 0x0000_4501, c=1), then (0x202, 0x0000_4505, c=1); fetch_addr reaches 0x204.
- Straddle: @0x200=0x0513_4501, @0x204=0x4505_0000 → (0x200, 0x4501, c=1), (0x202, 0x0000_0513, c=0), (0x206, 0x4505, c=1).
  - Also delay the 0x204 fetch_ready by 3 cycles → inst_valid=0 during those cycles with count=1.
- Redirect to 0x302, memory idle → next fetch_addr=0x300; @0x300=0x4505_AAAA → first inst_pc=0x302, raw 0x4505; 0xAAAA is never emitted.
- Redirect to 0x400 while 0x208 is outstanding (fetch_ready low 3 cycles) → DISCARD, fetch_addr held at 0x208.
  - Returned data dropped, then fetch_addr=0x400; no instruction with pc 0x208 is emitted.
- Backpressure: inst_ready=0 for 10 cycles with all-compressed code → count saturates at 4, fetch_ren=0.
  - On release, instructions emerge in order with contiguous PCs; none lost or duplicated.
- nRST asserted with count=1 (straddle half held) → outputs at reset values immediately.
  - After release, the first fetch is from 0x200.
